// File: rtl/seq_det_pkg.sv
// Shared types and constants for the runtime-programmable serial pattern detector.
// Optional match counter: compile with SEQ_DET_MATCH_CNT_EN defined to enable it.
package seq_det_pkg;

    // Controller states: waiting for first config, detecting, or bad config latched.
    typedef enum logic [1:0] {
        CFG_WAIT = 2'd0,
        RUN      = 2'd1,
        CFG_ERR  = 2'd2
    } seq_state_t;

    localparam int SEQ_DET_PAT_W = 8;
    localparam int SEQ_DET_CNT_W = 16;

    // One bit of the length mask: bit idx is part of a cfg_len-bit pattern
    // when idx < len. Callers build the full mask with a generate loop so the
    // mask width follows their own PAT_W.
    function automatic logic len_mask_bit(input int unsigned len, input int unsigned idx);
        return (idx < len);
    endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// Bus bundle for param_seq_detector: serial input, config, counter control and status.
// master = stimulus/controller side, slave = detector side.
interface param_seq_detector_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 16
) ();
    logic             din;
    logic             din_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap_en;
    logic             cnt_clr;
    logic             match_mealy;
    logic             match_moore;
    logic             cfg_err;
    logic             busy;
    logic [CNT_W-1:0] match_count;

    modport master (
        output din, din_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
        input  match_mealy, match_moore, cfg_err, busy, match_count
    );

    modport slave (
        input  din, din_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
        output match_mealy, match_moore, cfg_err, busy, match_count
    );
endinterface

// File: rtl/seq_det_match_cmp.sv
// Masked comparator: checks the low cfg_len bits of {hist,din} against the
// programmed pattern and confirms enough bits have been accepted.
module seq_det_match_cmp
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W:0]   window,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [LEN_W-1:0] fill,
    output logic             hit
);
    logic [PAT_W:0] mask;
    logic           bits_eq;
    logic           fill_ok;
    logic [LEN_W:0] fill_p1;

    // Bit PAT_W of the mask is always 0 because cfg_len never exceeds PAT_W.
    generate
        for (genvar gi = 0; gi <= PAT_W; gi++) begin : g_mask
            assign mask[gi] = len_mask_bit(32'(cfg_len), gi);
        end
    endgenerate

    assign bits_eq = (((window ^ {1'b0, cfg_pattern}) & mask) == '0);

    // fill >= cfg_len-1 rewritten as fill+1 >= cfg_len to avoid underflow.
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok = (fill_p1 >= {1'b0, cfg_len});

    assign hit = bits_eq & fill_ok;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with Mealy and registered
// match outputs. Optional saturating match counter under SEQ_DET_MATCH_CNT_EN;
// without it match_count is tied to zero and cnt_clr is ignored.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = SEQ_DET_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = SEQ_DET_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    param_seq_detector_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    seq_state_t       state_reg;
    logic [PAT_W-1:0] cfg_pattern_reg;
    logic [LEN_W-1:0] cfg_len_reg;
    logic             cfg_ovl_reg;
    logic             cfg_err_reg;
    logic             busy_reg;
    logic [PAT_W-1:0] hist_reg;
    logic [LEN_W-1:0] fill_reg;
    logic             match_moore_reg;

    logic             len_legal;
    logic             accept;
    logic             cmp_hit;
    logic             match_mealy;

    assign len_legal = (bus.pat_len != '0) && (bus.pat_len <= MAX_LEN);

    // A bit arriving together with cfg_load is dropped.
    assign accept = bus.din_valid && !bus.cfg_load;

    seq_det_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .window      ({hist_reg, bus.din}),
        .cfg_pattern (cfg_pattern_reg),
        .cfg_len     (cfg_len_reg),
        .fill        (fill_reg),
        .hit         (cmp_hit)
    );

    assign match_mealy = (state_reg == RUN) && accept && cmp_hit;

    // Controller: every state reacts to cfg_load the same way, latching the
    // config and choosing RUN or CFG_ERR from the length; otherwise it holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= CFG_WAIT;
            cfg_pattern_reg <= '0;
            cfg_len_reg     <= '0;
            cfg_ovl_reg     <= 1'b0;
            cfg_err_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (bus.cfg_load) begin
            cfg_pattern_reg <= bus.pattern;
            cfg_len_reg     <= bus.pat_len;
            cfg_ovl_reg     <= bus.overlap_en;
            if (len_legal) begin
                state_reg   <= RUN;
                busy_reg    <= 1'b1;
                cfg_err_reg <= 1'b0;
            end else begin
                state_reg   <= CFG_ERR;
                busy_reg    <= 1'b0;
                cfg_err_reg <= 1'b1;
            end
        end
    end

    // History/fill tracking: shift accepted bits in RUN, clear on reload or
    // after a non-overlapping match, and register the match pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_reg        <= '0;
            fill_reg        <= '0;
            match_moore_reg <= 1'b0;
        end else begin
            match_moore_reg <= match_mealy;
            if (bus.cfg_load) begin
                hist_reg <= '0;
                fill_reg <= '0;
            end else if (match_mealy && !cfg_ovl_reg) begin
                hist_reg <= '0;
                fill_reg <= '0;
            end else if (accept && (state_reg == RUN)) begin
                hist_reg <= {hist_reg[PAT_W-2:0], bus.din};
                if (fill_reg < cfg_len_reg) begin
                    fill_reg <= fill_reg + LEN_W'(1);
                end
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] count_reg;

    // Saturating match counter; a clear coinciding with a match leaves 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (bus.cnt_clr) begin
            count_reg <= match_mealy ? CNT_W'(1) : '0;
        end else if (match_mealy && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign bus.match_count = count_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = '0;
`endif

    assign bus.match_mealy = match_mealy;
    assign bus.match_moore = match_moore_reg;
    assign bus.cfg_err     = cfg_err_reg;
    assign bus.busy        = busy_reg;

endmodule
